// File: rtl/dffa_pipe_rstn.sv
// Multi-stage valid/ready pipeline register with asynchronous active-low reset and
// synchronous flush; empty stages collapse so bubbles never cost throughput.
module dffa_pipe_rstn #(
   parameter int unsigned    DW     = 8,
   parameter int unsigned    DEPTH  = 2,
   parameter logic [DW-1:0]  RST_VL = {DW{1'b0}},
   parameter int unsigned    CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_dat,
   output logic [CW-1:0] occ
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] up_vld;
   logic [DEPTH-1:0] rdy;
   logic [DW-1:0]    dat_q  [DEPTH];
   logic [DW-1:0]    dat_d  [DEPTH];
   logic [DW-1:0]    up_dat [DEPTH];
   logic [CW-1:0]    occ_cnt;

   // A stage may advance if it or any stage downstream of it is empty, or the sink takes data.
   // Accumulated from the output side so the vector has no bit-to-bit self dependency.
   always_comb begin
      logic acc;
      acc = out_rdy;
      rdy = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         acc    = acc | ~vld_q[k];
         rdy[k] = acc;
      end
   end

   always_comb begin
      up_vld[0] = in_vld & ~flush;
      up_dat[0] = in_dat;
      for (int k = 1; k < int'(DEPTH); k++) begin
         up_vld[k] = vld_q[k-1];
         up_dat[k] = dat_q[k-1];
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
         vld_d[k] = flush ? 1'b0 : (rdy[k] ? up_vld[k] : vld_q[k]);
         // Data only loads on a real transfer so bubbles do not toggle the registers.
         dat_d[k] = (rdy[k] & up_vld[k]) ? up_dat[k] : dat_q[k];
      end
   end

   always_comb begin
      occ_cnt = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         occ_cnt = occ_cnt + CW'(vld_q[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            dat_q[k] <= RST_VL;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < int'(DEPTH); k++) begin
            dat_q[k] <= dat_d[k];
         end
      end
   end

   assign in_rdy  = rdy[0] & ~flush;
   assign out_vld = vld_q[DEPTH-1];
   assign out_dat = dat_q[DEPTH-1];
   assign occ     = occ_cnt;

endmodule

// File: tb/tb_dffa_pipe_rstn.sv
// Directed bench for dffa_pipe_rstn: a DEPTH=3 instance with a non-zero reset value and a
// DEPTH=1 instance driven pseudo-randomly against a queue model.
module tb_dffa_pipe_rstn;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       d3_flush, d3_in_vld, d3_in_rdy, d3_out_vld, d3_out_rdy;
   logic [7:0] d3_in_dat, d3_out_dat;
   logic [1:0] d3_occ;

   logic       d1_flush, d1_in_vld, d1_in_rdy, d1_out_vld, d1_out_rdy;
   logic [7:0] d1_in_dat, d1_out_dat;
   logic       d1_occ;

   int n_chk = 0;
   int n_bad = 0;

   dffa_pipe_rstn #(.DW(8), .DEPTH(3), .RST_VL(8'hA5)) u_dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (d3_flush),
      .in_vld  (d3_in_vld),
      .in_rdy  (d3_in_rdy),
      .in_dat  (d3_in_dat),
      .out_vld (d3_out_vld),
      .out_rdy (d3_out_rdy),
      .out_dat (d3_out_dat),
      .occ     (d3_occ)
   );

   dffa_pipe_rstn #(.DW(8), .DEPTH(1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (d1_flush),
      .in_vld  (d1_in_vld),
      .in_rdy  (d1_in_rdy),
      .in_dat  (d1_in_dat),
      .out_vld (d1_out_vld),
      .out_rdy (d1_out_rdy),
      .out_dat (d1_out_dat),
      .occ     (d1_occ)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic d3_drive(input logic vld, input logic [7:0] dat, input logic ordy,
                           input logic fl);
      @(negedge clk);
      d3_in_vld  = vld;
      d3_in_dat  = dat;
      d3_out_rdy = ordy;
      d3_flush   = fl;
      #1;
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] exp_list [3];
      logic       take, exp_rdy;

      d3_flush = 0; d3_in_vld = 0; d3_in_dat = 0; d3_out_rdy = 0;
      d1_flush = 0; d1_in_vld = 0; d1_in_dat = 0; d1_out_rdy = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_vld", 32'(d3_out_vld), 32'd0);
      check("rst_out_dat", 32'(d3_out_dat), 32'hA5);
      check("rst_occ",     32'(d3_occ),     32'd0);
      check("rst_in_rdy",  32'(d3_in_rdy),  32'd1);
      rst_n = 1'b1;

      // Streaming 0x01..0x10, out_rdy=1
      for (int c = 0; c < 20; c++) begin
         d3_drive(c < 16, 8'(c + 1), 1'b1, 1'b0);
         if (c < 16) check("strm_in_rdy", 32'(d3_in_rdy), 32'd1);
         check("strm_out_vld", 32'(d3_out_vld), 32'(c >= 3 && c < 19));
         if (c >= 3 && c < 19) check("strm_out_dat", 32'(d3_out_dat), 32'(c - 2));
      end

      // Backpressure: fill with out_rdy=0
      for (int c = 0; c < 4; c++) begin
         d3_drive(1'b1, 8'(8'h20 + c), 1'b0, 1'b0);
         check("bp_occ",    32'(d3_occ),    32'(c));
         check("bp_in_rdy", 32'(d3_in_rdy), 32'(c < 3));
      end
      check("bp_out_dat", 32'(d3_out_dat), 32'h20);
      d3_drive(1'b1, 8'h23, 1'b0, 1'b0);
      check("bp_hold_in_rdy", 32'(d3_in_rdy), 32'd0);
      d3_drive(1'b1, 8'h23, 1'b1, 1'b0);
      check("bp_rel_in_rdy", 32'(d3_in_rdy),  32'd1);
      check("bp_rel_dat",    32'(d3_out_dat), 32'h20);
      d3_drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("bp_after_occ", 32'(d3_occ),     32'd3);
      check("bp_after_dat", 32'(d3_out_dat), 32'h21);
      exp_list = '{8'h21, 8'h22, 8'h23};
      for (int i = 0; i < 3; i++) begin
         d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
         check("bp_drain_vld", 32'(d3_out_vld), 32'd1);
         check("bp_drain_dat", 32'(d3_out_dat), 32'(exp_list[i]));
      end
      d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("bp_empty", 32'(d3_out_vld), 32'd0);

      // Bubble collapse
      d3_drive(1'b1, 8'h30, 1'b0, 1'b0);
      d3_drive(1'b0, 8'h00, 1'b0, 1'b0);
      d3_drive(1'b0, 8'h00, 1'b0, 1'b0);
      d3_drive(1'b1, 8'h31, 1'b0, 1'b0);
      check("bub_in_rdy1", 32'(d3_in_rdy), 32'd1);
      d3_drive(1'b1, 8'h32, 1'b0, 1'b0);
      check("bub_in_rdy2", 32'(d3_in_rdy), 32'd1);
      d3_drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("bub_occ",  32'(d3_occ),    32'd3);
      check("bub_full", 32'(d3_in_rdy), 32'd0);
      exp_list = '{8'h30, 8'h31, 8'h32};
      for (int i = 0; i < 3; i++) begin
         d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
         check("bub_drain_dat", 32'(d3_out_dat), 32'(exp_list[i]));
      end

      // Flush with occ=2 while in_vld=1
      d3_drive(1'b1, 8'h40, 1'b0, 1'b0);
      d3_drive(1'b1, 8'h41, 1'b0, 1'b0);
      d3_drive(1'b1, 8'h42, 1'b0, 1'b1);
      check("fl_occ_before", 32'(d3_occ),    32'd2);
      check("fl_in_rdy",     32'(d3_in_rdy), 32'd0);
      d3_drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("fl_occ_after", 32'(d3_occ),     32'd0);
      check("fl_out_vld",   32'(d3_out_vld), 32'd0);
      for (int i = 0; i < 4; i++) begin
         d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
         check("fl_no_output", 32'(d3_out_vld), 32'd0);
      end

      // Asynchronous reset mid-stream
      d3_drive(1'b1, 8'h50, 1'b1, 1'b0);
      d3_drive(1'b1, 8'h51, 1'b1, 1'b0);
      d3_drive(1'b1, 8'h52, 1'b1, 1'b0);
      check("mr_occ_before", 32'(d3_occ), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      check("mr_out_vld", 32'(d3_out_vld), 32'd0);
      check("mr_out_dat", 32'(d3_out_dat), 32'hA5);
      check("mr_occ",     32'(d3_occ),     32'd0);
      check("mr_in_rdy",  32'(d3_in_rdy),  32'd1);
      d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d3_drive(1'b0, 8'h00, 1'b1, 1'b0);
         check("mr_no_output", 32'(d3_out_vld), 32'd0);
      end

      // DEPTH=1 against a queue model
      take = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (take || !d1_in_vld) begin
            d1_in_vld = 1'($urandom_range(0, 1));
            d1_in_dat = 8'($urandom);
         end
         d1_out_rdy = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = (q.size() == 0) || d1_out_rdy;
         check("d1_in_rdy",  32'(d1_in_rdy),  32'(exp_rdy));
         check("d1_occ",     32'(d1_occ),     32'(q.size()));
         check("d1_out_vld", 32'(d1_out_vld), 32'(q.size() != 0));
         if (q.size() != 0 && d1_out_rdy) begin
            check("d1_out_dat", 32'(d1_out_dat), 32'(q[0]));
            void'(q.pop_front());
         end
         take = d1_in_vld && exp_rdy;
         if (take) q.push_back(d1_in_dat);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dffa_pipe_rstn.md
# dffa_pipe_rstn

Parametrised multi-stage pipeline register with valid/ready handshake, asynchronous active-low reset and synchronous flush. It generalises the single asynchronous-reset D flip-flop to a chain of DEPTH registered stages of DW bits each. Each stage has its own valid bit and backpressure, and empty stages collapse so bubbles are removed. It is used to retime long paths in the AHB/APB bridge datapath without losing throughput.

## Interface
Parameters:
- DW, 8: data width in bits; legal values are 1 and above.
- DEPTH, 2: number of register stages; legal range 1..8.
- RST_VL, {DW{1'b0}}: reset value of every stage data register.
- CW, $clog2(DEPTH+1): occupancy width. Derived; do not override.

Ports (name, direction, width, meaning):
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous clear of all stage valid bits.
- in_vld, input, 1: upstream data valid.
- in_rdy, output, 1: pipeline can accept in_dat this cycle.
- in_dat, input, DW: upstream data.
- out_vld, output, 1: output stage holds valid data.
- out_rdy, input, 1: downstream accepts out_dat this cycle.
- out_dat, output, DW: output stage data.
- occ, output, CW: number of stages currently holding valid data.

## Operation
- Stages are indexed 0 (input side) to DEPTH-1 (output side). Each stage k holds vld[k] and dat[k].
- Ready chain (combinational):
  - rdy[DEPTH] = out_rdy.
  - rdy[k] = !vld[k] | rdy[k+1].
  - in_rdy = rdy[0] & !flush.
- Input transfer: in_vld & in_rdy. Output transfer: out_vld & out_rdy.
- Stage k update on a clock edge when rdy[k] is 1:
  - vld[k] <= upstream valid. For stage 0 the upstream valid is in_vld & !flush; for stage k>0 it is vld[k-1].
  - dat[k] <= upstream data, but only when the upstream valid is 1. Otherwise dat[k] holds its value (no toggling on bubbles).
- When rdy[k] is 0, stage k holds both vld[k] and dat[k].
- out_vld = vld[DEPTH-1]. out_dat = dat[DEPTH-1].
- occ = popcount(vld[DEPTH-1:0]), computed combinationally.
- flush:
  - On the next edge, all vld[k] go to 0. Data registers are not cleared.
  - in_rdy is forced to 0 during the flush cycle, so no input is accepted.
  - An output transfer in the flush cycle is legal and counts as consumed.
- Reset (rst_n low, asynchronous):
  - All vld go to 0 and all dat go to RST_VL.
  - Resulting outputs: out_vld=0, out_dat=RST_VL, occ=0, in_rdy=1 (pipeline empty, flush low).
  - Reset asserted mid-transfer discards all held data with no output.
- Ordering is preserved; no data is duplicated or dropped except by flush or reset.
- Upstream must hold in_vld/in_dat stable until accepted. Downstream sees out_vld/out_dat stable until out_rdy.

## Timing
- Latency into an empty pipe with out_rdy=1 throughout: data accepted at edge 0 appears on out_dat with out_vld=1 after DEPTH-1 further edges. That is, it is presented DEPTH cycles after the cycle in which in_vld was sampled.
- Throughput is one transfer per cycle in steady state with out_rdy=1.
- Backpressure: when out_rdy=0, the pipe fills. in_rdy drops in the cycle where every vld[k]=1, and occ=DEPTH in that cycle.
- Bubble collapse: a stalled output with empty upstream stages still accepts input until full.
- out_rdy to in_rdy is a combinational path through DEPTH OR gates. The integrator must budget for it.
- DEPTH=1 degenerates to a single register stage: in_rdy = (!vld[0] | out_rdy) & !flush.
- Simultaneous input and output transfer when full: both complete, and occ is unchanged.

## Test plan
- Reset: assert rst_n=0 mid-stream with DEPTH=3 and RST_VL=8'hA5 -> out_vld=0, out_dat=8'hA5, occ=0, in_rdy=1 immediately, without waiting for a clock.
- Streaming: DEPTH=3 with out_rdy=1, send 0x01..0x10 back-to-back -> first out_vld 3 cycles after the first acceptance, then 16 consecutive outputs in order, with in_rdy constantly 1.
- Backpressure: out_rdy=0 with continuous input -> occ counts 1,2,3 and in_rdy=0 at occ=3. Release out_rdy for one cycle -> exactly one output and one input transfer, with occ staying 3.
- Bubble collapse: load one word, hold out_rdy=0, insert 2 idle cycles, then send 2 words -> all 3 accepted, occ=3, and output order is preserved when out_rdy=1.
- Flush: with occ=2, pulse flush for 1 cycle while in_vld=1 -> in_rdy=0 in that cycle, occ=0 and out_vld=0 next cycle, and the flushed input is never output.
- DEPTH=1 corner: random in_vld/out_rdy for 1000 cycles against a scoreboard -> no loss or duplication, and occ is always 0 or 1.
